// File: rtl/key_debounce_pkg.sv
// Shared key definitions: debounce FSM state encodings, the default
// debounce interval and small helpers used by key/LED logic.
package key_debounce_pkg;

    // 20 ms at a 50 MHz system clock
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1000000;

    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'b00,
        KEY_PRESS_WAIT   = 2'b01,
        KEY_PRESSED      = 2'b10,
        KEY_RELEASE_WAIT = 2'b11
    } key_fsm_e;

    // The debounced level is "down" while pressed or while a release is
    // still being qualified.
    function automatic logic key_is_down(input key_fsm_e st);
        return (st == KEY_PRESSED) || (st == KEY_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, four-state qualification FSM
// with a saturating-free sample counter, and registered level/pulse outputs.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic           sync1_r;
    logic           sync2_r;
    key_fsm_e       state_r;
    key_fsm_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic           down_s;
    logic           press_s;
    logic           release_s;
    logic           key_state_r;
    logic           key_press_r;
    logic           key_release_r;

    // Bring the raw push-button into the clock domain; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    // FSM state and sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= KEY_RELEASED;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: any opposite sample while qualifying aborts; the counter is
    // cleared on every state entry so it can never pass CNT_LAST.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            KEY_RELEASED: begin
                if (!sync2_r) begin
                    state_s = KEY_PRESS_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = KEY_RELEASED;
                    cnt_s   = CNT_ZERO;
                end
            end
            KEY_PRESS_WAIT: begin
                if (sync2_r) begin
                    state_s = KEY_RELEASED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = KEY_PRESSED;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = KEY_PRESS_WAIT;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            KEY_PRESSED: begin
                if (sync2_r) begin
                    state_s = KEY_RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = KEY_PRESSED;
                    cnt_s   = CNT_ZERO;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (!sync2_r) begin
                    state_s = KEY_PRESSED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = KEY_RELEASED;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = KEY_RELEASE_WAIT;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = KEY_RELEASED;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the transition being taken this cycle.
    always_comb begin
        down_s    = key_is_down(state_s);
        press_s   = (state_r == KEY_PRESS_WAIT)   && (state_s == KEY_PRESSED);
        release_s = (state_r == KEY_RELEASE_WAIT) && (state_s == KEY_RELEASED);
    end

    // Register the outputs so they appear together with the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_r   <= 1'b0;
            key_press_r   <= 1'b0;
            key_release_r <= 1'b0;
        end else begin
            key_state_r   <= down_s;
            key_press_r   <= press_s;
            key_release_r <= release_s;
        end
    end

    assign key_state   = key_state_r;
    assign key_press   = key_press_r;
    assign key_release = key_release_r;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent active-low push-button channels
// producing an active-high debounced level plus press/release pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_in     (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (NUM_KEYS=4, DEBOUNCE_CYCLES=8):
// stimulus pushes the expected pulse events, a monitor pops and compares
// whenever a press/release pulse appears.
module tb_key_debounce;

    localparam int LAT = 11;

    typedef struct {
        int       cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    key_debounce #(
        .NUM_KEYS(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.state = s;
        sb_q.push_back(e);
    endtask

    task automatic check_outs(input string name, input logic [3:0] s, input logic [3:0] p, input logic [3:0] r);
        checks++;
        if (key_state !== s || key_press !== p || key_release !== r) begin
            errors++;
            $display("FAIL %s cyc=%0d actual state=%b press=%b release=%b required state=%b press=%b release=%b",
                     name, cyc, key_state, key_press, key_release, s, p, r);
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout cyc=%0d actual pending=%0d required pending=0", name, cyc, sb_q.size());
            sb_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            if ((|key_press) || (|key_release)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d actual press=%b release=%b state=%b required no pulse",
                             cyc, key_press, key_release, key_state);
                end else begin
                    e = sb_q.pop_front();
                    if (cyc != e.cyc || key_press !== e.press || key_release !== e.rel || key_state !== e.state) begin
                        errors++;
                        $display("FAIL pulse_event actual cyc=%0d press=%b release=%b state=%b required cyc=%0d press=%b release=%b state=%b",
                                 cyc, key_press, key_release, key_state, e.cyc, e.press, e.rel, e.state);
                    end
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                checks++;
                errors++;
                e = sb_q.pop_front();
                $display("FAIL missed_pulse cyc=%0d actual no pulse required press=%b release=%b at cyc=%0d",
                         cyc, e.press, e.rel, e.cyc);
            end
        end
    end

    // Directed stimulus.
    initial begin
        int       fall_cyc;
        logic     lvl;
        logic     prev;

        rst    = 1'b1;
        key_in = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check_outs("reset_hold", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        push(cyc + LAT, 4'b1111, 4'b0000, 4'b1111);
        drain("reset_release_press", 30);
        check_outs("held_after_reset", 4'b1111, 4'b0000, 4'b0000);

        key_in = 4'b1111;
        push(cyc + LAT, 4'b0000, 4'b1111, 4'b0000);
        drain("release_all_1", 30);
        check_outs("idle_1", 4'b0000, 4'b0000, 4'b0000);

        // Clean press on key 0
        key_in[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 4'b0000, 4'b0001);
        drain("clean_press", 30);
        check_outs("key0_held", 4'b0001, 4'b0000, 4'b0000);

        // Bounce on key 1: 3-cycle runs, then held low
        prev     = 1'b1;
        fall_cyc = cyc;
        for (int t = 0; t < 40; t++) begin
            lvl = ((t / 3) % 2) != 0;
            if (!lvl && prev) fall_cyc = cyc;
            key_in[1] = lvl;
            prev = lvl;
            @(negedge clk);
        end
        if (prev) fall_cyc = cyc;
        key_in[1] = 1'b0;
        check_outs("bounce_no_change", 4'b0001, 4'b0000, 4'b0000);
        push(fall_cyc + LAT, 4'b0010, 4'b0000, 4'b0011);
        drain("bounce_press", 30);
        check_outs("key01_held", 4'b0011, 4'b0000, 4'b0000);

        // Release key 0, then key 1
        key_in[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001, 4'b0010);
        drain("release_key0", 30);
        key_in[1] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
        drain("release_key1", 30);

        // Reset while key 2 press count is at 5
        key_in[2] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_outs("midcount_reset", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        push(cyc + LAT, 4'b0100, 4'b0000, 4'b0100);
        drain("requalify_key2", 30);
        key_in[2] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
        drain("release_key2", 30);

        // All keys fall on the same edge
        key_in = 4'b0000;
        push(cyc + LAT, 4'b1111, 4'b0000, 4'b1111);
        drain("simultaneous_press", 30);
        key_in = 4'b1111;
        push(cyc + LAT, 4'b0000, 4'b1111, 4'b0000);
        drain("simultaneous_release", 30);
        check_outs("final_idle", 4'b0000, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 4, is the number of independent key channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), is the number of consecutive stable samples required to accept a level change; legal range 2..2^24.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  NUM_KEYS  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 key_state  output  NUM_KEYS  debounced level, active-high (1 = pressed), registered.
REQ-007 key_press  output  NUM_KEYS  one-cycle pulse on an accepted press, registered.
REQ-008 key_release  output  NUM_KEYS  one-cycle pulse on an accepted release, registered.

Function
REQ-009 Each key_in bit SHALL pass through its own 2-flop synchronizer; the synchronizer flops reset to 1 (released).
REQ-010 Each channel SHALL run an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 RELEASED: if the synchronized input is 0, go to PRESS_WAIT with cnt=0; otherwise stay.
REQ-012 PRESS_WAIT: if the input is 1, return to RELEASED (bounce rejected, no pulse); else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED; else cnt+1.
REQ-013 PRESSED: if the input is 1, go to RELEASE_WAIT with cnt=0; otherwise stay.
REQ-014 RELEASE_WAIT: if the input is 0, return to PRESSED (no pulse); else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED; else cnt+1.
REQ-015 key_state[i] SHALL be 1 exactly while the FSM is in PRESSED or RELEASE_WAIT.
REQ-016 key_press[i] SHALL be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED transition; key_release[i] SHALL behave likewise for RELEASE_WAIT->RELEASED.
REQ-017 Latency: with key_in held low, key_state rises and key_press pulses after the (DEBOUNCE_CYCLES+3)th rising edge that samples key_in low, counting the first such edge as 1; release is symmetric.
REQ-018 Any input reversal shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change; the next opposite-level sample restarts counting from 0.
REQ-019 The counter SHALL never wrap; it is cleared on every state entry and cannot exceed DEBOUNCE_CYCLES-1.
REQ-020 Channels SHALL be fully independent; simultaneous press/release pulses on different channels in the same cycle are legal.
REQ-021 key_press[i] and key_release[i] SHALL never be asserted in the same cycle.

Reset
REQ-022 While rst=1, all FSMs SHALL be in RELEASED, counters 0, synchronizers 1, and key_state, key_press and key_release all 0.
REQ-023 Reset asserted mid-count or mid-pulse SHALL abort immediately with no pulse emitted; after deassertion a key still held down SHALL be re-qualified from RELEASED, giving a full press latency.

Structure
REQ-024 FSM state encodings (2-bit) and the default DEBOUNCE_CYCLES constant SHALL live in the shared key package/header used by the downstream key/LED logic.
REQ-025 One sub-module, key_debounce_ch (synchronizer, FSM and counter for one key), SHALL be instantiated NUM_KEYS times through a generate loop; the top level contains no other logic.

Verification (DEBOUNCE_CYCLES=8, NUM_KEYS=4)
REQ-026 Reset: hold rst for 3 cycles with key_in=4'b0000 -> all outputs 0 throughout; after release, key_state=4'b1111 and one key_press pulse per bit, both 11 edges later.
REQ-027 Clean press: key_in[0] goes 1->0 and is held -> key_state[0] rises and key_press[0] is high for one cycle after edge 11; other bits stay 0.
REQ-028 Bounce: key_in[1] toggles 0/1 every 3 cycles for 40 cycles, then is held at 0 -> no pulse during the toggling; exactly one key_press[1] pulse, 11 edges after the final fall.
REQ-029 Release: key_in[0] returns to 1 while pressed -> key_state[0] falls and key_release[0] pulses once after edge 11.
REQ-030 Reset mid-count: assert rst when the key_in[2] press count is at 5 -> no pulse; after deassertion with the key still held, the press is accepted 11 edges later.
REQ-031 Simultaneous: key_in[3:0] all fall on the same edge -> key_press=4'b1111 for exactly one cycle.
